red_pitaya_pwm_mc: RTL and testbench
====================================

Name: red_pitaya_pwm_mc

Overview:
Multi-channel PWM DAC generator for driving RC-filtered slow analog outputs. It is the parametrised successor of the single-channel 24-bit PWM. All channels share one period counter. Each channel has a coarse duty value and a fractional dither word. Fractional resolution comes either from a first-order sigma-delta accumulator (new) or from the legacy bit-serial frame dither, selected per channel. The block sits between the housekeeping/ams register bank and the PWM output pins.

Parameters:
NCH, 4, number of PWM channels
VW, 8, coarse duty width in bits
DW, 16, fractional dither width in bits; also the legacy frame length in periods
FULL, 255, last period-counter value; period = FULL+1 clk cycles; requires 2 <= FULL <= 2^VW-1

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
cfg  in  NCH*(VW+DW)  per channel k: bits [k*(VW+DW) +: VW+DW] = {coarse[VW-1:0], frac[DW-1:0]}
en  in  NCH  per-channel enable
mode  in  NCH  per-channel dither mode: 0 = sigma-delta, 1 = legacy bit-serial
pwm_o  out  NCH  registered PWM outputs
pwm_s  out  1  period strobe
frame_s  out  1  legacy frame strobe

Behaviour:
- Reset state: cnt=0, bcnt=0, all acc/shift/duty/coarse_h/mode_h registers = 0, pwm_o=0, pwm_s=0, frame_s=0.
- cnt counts 0..FULL and wraps to 0.
- bcnt counts periods 0..DW-1; it increments when cnt==FULL and wraps to 0.
- Period boundary (PB): the clock edge at which cnt==FULL. All per-channel updates below occur only at a PB.
- Frame boundary (FB): a PB with bcnt==DW-1.
- mode_h[k] <= mode[k] only at an FB, and on the first PB after reset.
  - On any change of mode_h[k], acc[k] and sr[k] are cleared.
- Sigma-delta (mode_h=0), at each PB:
  - s = {1'b0,acc[k]} + frac_k (DW+1 bits); acc[k] <= s[DW-1:0]; carry = s[DW].
  - duty[k] <= min(coarse_k + carry, FULL+1), computed at VW+1 bits.
  - cfg is therefore sampled every period.
- Legacy (mode_h=1):
  - At an FB: coarse_h[k] <= coarse_k; sr[k] <= frac_k.
  - At any other PB: sr[k] <= sr[k] >> 1.
  - At each PB: duty[k] <= min(coarse_h[k] + sr_next[k][0], FULL+1), where sr_next is the value being loaded at that edge.
  - Frac bit i therefore adds 1 to period i of the frame.
- en[k]=0 at a PB: duty[k] <= 0 and acc[k], sr[k] are cleared. The output goes low from the next period onward; the current period completes unchanged. Re-enabling restarts the accumulator from 0.
- Output: pwm_o[k] <= ({1'b0,cnt} < duty[k]).
  - pwm_o lags cnt by one cycle.
  - High time per period is exactly duty[k] cycles (0..FULL+1). duty = FULL+1 gives a constant high level.
- Latency: cfg value present at PB edge n is reflected in pwm_o from cycle n+2 (one cycle for the duty register, one for the output register).
- Mean duty in sigma-delta mode = (coarse + frac/2^DW)/(FULL+1), exact over 2^DW periods.
- pwm_s <= (cnt==FULL-1): high for exactly the one cycle in which cnt==FULL, i.e. the PB sample cycle.
- frame_s <= (cnt==FULL-1 && bcnt==DW-1): same timing as pwm_s, restricted to the FB.
- Reset mid-period forces all outputs low on the next edge and restarts at cnt=0 with no partial pulse.
- Channels are independent except for the shared cnt and bcnt.

Test Plan:
- Sigma-delta, ch0, coarse=100, frac=0x8000, en=1, FULL=255 -> pwm_o[0] high-counts alternate 100,101 over 8 periods; first period after reset high 0 cycles.
- Sigma-delta, coarse=100, frac=0x0000 -> every period high exactly 100 cycles; coarse=255, frac=0xFFFF -> high-count 256 (constant high) in all but one of every 65536 periods, sampled over 16 periods.
- Legacy ch1, coarse=50, frac=0x0005 loaded at an FB -> frame periods 0 and 2 high 51, others 50; mid-frame cfg change ignored until the next FB.
- en[2] dropped mid-period with coarse=200 -> current period still high 200, following periods 0; re-enable -> resumes at 200 with acc restarted at 0.
- pwm_s, frame_s -> pwm_s one-cycle pulse every 256 cycles, coincident with cnt==255; frame_s every 4096 cycles; mode[3] toggled mid-frame takes effect only at the next frame_s.
- rstn asserted for 1 cycle at cnt=37 with all channels high -> pwm_o=0 next cycle, cnt restarts at 0, pwm_s next high 256 cycles after reset release.

Source files
------------

// File: rtl/red_pitaya_pwm_mc_if.sv
// Bundle of the signals between the housekeeping register bank and the
// multi-channel PWM generator.
//   cfg     : per channel k, bits [k*(VW+DW) +: VW+DW] = {coarse, frac}
//   en      : per-channel enable
//   mode    : per-channel dither mode (0 = sigma-delta, 1 = legacy bit-serial)
//   pwm_o   : registered PWM outputs
//   pwm_s   : period strobe
//   frame_s : legacy frame strobe
// master = register-bank side, slave = PWM generator side.
interface red_pitaya_pwm_mc_if #(
    parameter int NCH = 4,
    parameter int VW  = 8,
    parameter int DW  = 16
);
    logic [NCH*(VW+DW)-1:0] cfg;
    logic [NCH-1:0]         en;
    logic [NCH-1:0]         mode;
    logic [NCH-1:0]         pwm_o;
    logic                   pwm_s;
    logic                   frame_s;

    modport master (output cfg, en, mode, input  pwm_o, pwm_s, frame_s);
    modport slave  (input  cfg, en, mode, output pwm_o, pwm_s, frame_s);
endinterface

// File: rtl/red_pitaya_pwm_mc.sv
// Multi-channel PWM DAC generator for RC-filtered slow analog outputs.
// All channels share one period counter (0..FULL) and one period-in-frame
// counter (0..DW-1). Each channel adds fractional resolution to its coarse
// duty either with a first-order sigma-delta accumulator or with the legacy
// bit-serial frame dither, selected per channel.
// Ports:
//   clk  : clock
//   rstn : synchronous, active-low reset
//   bus  : slave side of red_pitaya_pwm_mc_if (cfg/en/mode in,
//          pwm_o/pwm_s/frame_s out)
module red_pitaya_pwm_mc #(
    parameter int NCH  = 4,
    parameter int VW   = 8,
    parameter int DW   = 16,
    parameter int FULL = 255
) (
    input  logic               clk,
    input  logic               rstn,
    red_pitaya_pwm_mc_if.slave bus
);
    localparam int          CW   = VW + DW;
    localparam int          BW   = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [VW:0] DMAX = (VW+1)'(FULL + 1);

    // Registered state
    logic [VW-1:0]  r_cnt;
    logic [BW-1:0]  r_bcnt;
    logic           r_first;        // next PB is the first one after reset
    logic [NCH-1:0] r_mode_h;
    logic [DW-1:0]  r_acc      [NCH];
    logic [DW-1:0]  r_sr       [NCH];
    logic [VW-1:0]  r_coarse_h [NCH];
    logic [VW:0]    r_duty     [NCH];
    logic [NCH-1:0] r_pwm;
    logic           r_pwm_s;
    logic           r_frame_s;

    // Combinational next-state
    logic           w_pb;
    logic           w_fb;
    logic           w_pre;
    logic           w_last_b;
    logic [NCH-1:0] w_mode_nxt;
    logic [NCH-1:0] w_chg;
    logic [VW-1:0]  w_coarse   [NCH];
    logic [DW-1:0]  w_frac     [NCH];
    logic [DW-1:0]  w_acc_in   [NCH];
    logic [DW-1:0]  w_sr_in    [NCH];
    logic [DW:0]    w_sum      [NCH];
    logic [VW:0]    w_raw      [NCH];
    logic [DW-1:0]  w_acc_nxt  [NCH];
    logic [DW-1:0]  w_sr_nxt   [NCH];
    logic [VW-1:0]  w_ch_nxt   [NCH];
    logic [VW:0]    w_duty_nxt [NCH];

    // Duty is capped at FULL+1, which already means "high all period".
    function automatic logic [VW:0] f_sat(input logic [VW:0] x);
        return (x > DMAX) ? DMAX : x;
    endfunction

    assign w_pb     = (r_cnt == VW'(FULL));
    assign w_pre    = (r_cnt == VW'(FULL - 1));
    assign w_last_b = (r_bcnt == BW'(DW - 1));
    assign w_fb     = w_pb && w_last_b;

    always_comb begin
        w_mode_nxt = r_mode_h;
        w_chg      = '0;
        for (int k = 0; k < NCH; k++) begin
            w_coarse[k] = bus.cfg[k*CW+DW +: VW];
            w_frac[k]   = bus.cfg[k*CW +: DW];

            // The held mode only follows the input at frame boundaries, so a
            // legacy frame is never cut in half; a change wipes dither state.
            if (w_fb || r_first) begin
                w_mode_nxt[k] = bus.mode[k];
            end
            w_chg[k]    = (w_mode_nxt[k] != r_mode_h[k]);
            w_acc_in[k] = w_chg[k] ? '0 : r_acc[k];
            w_sr_in[k]  = w_chg[k] ? '0 : r_sr[k];

            w_sum[k]     = {1'b0, w_acc_in[k]} + {1'b0, w_frac[k]};
            w_acc_nxt[k] = w_acc_in[k];
            w_sr_nxt[k]  = w_sr_in[k];
            w_ch_nxt[k]  = r_coarse_h[k];

            if (!w_mode_nxt[k]) begin
                // Sigma-delta: the accumulator carry adds one LSB of duty.
                w_acc_nxt[k] = w_sum[k][DW-1:0];
                w_raw[k]     = {1'b0, w_coarse[k]} + (VW+1)'(w_sum[k][DW]);
            end else begin
                // Legacy: frac is latched once per frame and shifted out one
                // bit per period; bit 0 lands in frame period 0.
                if (w_fb) begin
                    w_ch_nxt[k] = w_coarse[k];
                    w_sr_nxt[k] = w_frac[k];
                end else begin
                    w_sr_nxt[k] = w_sr_in[k] >> 1;
                end
                w_raw[k] = {1'b0, w_ch_nxt[k]} + (VW+1)'(w_sr_nxt[k][0]);
            end

            if (!bus.en[k]) begin
                w_acc_nxt[k]  = '0;
                w_sr_nxt[k]   = '0;
                w_duty_nxt[k] = '0;
            end else begin
                w_duty_nxt[k] = f_sat(w_raw[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_bcnt    <= '0;
            r_first   <= 1'b1;
            r_mode_h  <= '0;
            r_pwm     <= '0;
            r_pwm_s   <= 1'b0;
            r_frame_s <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_acc[k]      <= '0;
                r_sr[k]       <= '0;
                r_coarse_h[k] <= '0;
                r_duty[k]     <= '0;
            end
        end else begin
            r_cnt     <= w_pb ? '0 : r_cnt + VW'(1);
            // Strobes are registered one count early so they coincide with
            // the cycle in which cnt==FULL.
            r_pwm_s   <= w_pre;
            r_frame_s <= w_pre && w_last_b;
            if (w_pb) begin
                r_bcnt   <= w_last_b ? '0 : r_bcnt + BW'(1);
                r_first  <= 1'b0;
                r_mode_h <= w_mode_nxt;
                for (int k = 0; k < NCH; k++) begin
                    r_acc[k]      <= w_acc_nxt[k];
                    r_sr[k]       <= w_sr_nxt[k];
                    r_coarse_h[k] <= w_ch_nxt[k];
                    r_duty[k]     <= w_duty_nxt[k];
                end
            end
            for (int k = 0; k < NCH; k++) begin
                r_pwm[k] <= ({1'b0, r_cnt} < r_duty[k]);
            end
        end
    end

    assign bus.pwm_o   = r_pwm;
    assign bus.pwm_s   = r_pwm_s;
    assign bus.frame_s = r_frame_s;

endmodule

// File: tb/tb_red_pitaya_pwm_mc.sv
module tb_red_pitaya_pwm_mc;
    localparam int NCH  = 4;
    localparam int VW   = 8;
    localparam int DW   = 16;
    localparam int FULL = 255;
    localparam int CW   = VW + DW;

    typedef logic [NCH-1:0][VW:0] dvec_t;

    logic clk;
    logic rstn;

    red_pitaya_pwm_mc_if #(.NCH(NCH), .VW(VW), .DW(DW)) bus ();

    red_pitaya_pwm_mc #(.NCH(NCH), .VW(VW), .DW(DW), .FULL(FULL)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the period position and, at each period
    // boundary, works out the high time of the coming period per channel.
    dvec_t exp_q[$];
    int    m_cnt = 0;
    int    m_bcnt = 0;
    int    m_rst_cnt = 0;
    bit    m_first = 1'b1;
    bit    m_mode [NCH];
    int    m_acc  [NCH];   // sigma-delta fractional accumulator
    int    m_ch   [NCH];   // legacy coarse held for the frame
    int    m_ff   [NCH];   // legacy frac word of the current frame

    initial begin
        dvec_t e;
        bit    fb, nm;
        int    c, f, s, d, idx;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_cnt = 0; m_bcnt = 0; m_first = 1'b1;
                for (int k = 0; k < NCH; k++) begin
                    m_mode[k] = 1'b0; m_acc[k] = 0; m_ch[k] = 0; m_ff[k] = 0;
                end
                exp_q.delete();
                exp_q.push_back('0);
                m_rst_cnt++;
            end else if (m_cnt == FULL) begin
                fb = (m_bcnt == DW - 1);
                for (int k = 0; k < NCH; k++) begin
                    c  = int'(bus.cfg[k*CW+DW +: VW]);
                    f  = int'(bus.cfg[k*CW +: DW]);
                    nm = (fb || m_first) ? bus.mode[k] : m_mode[k];
                    if (nm != m_mode[k]) begin
                        m_acc[k] = 0; m_ff[k] = 0;
                    end
                    m_mode[k] = nm;
                    if (!nm) begin
                        s = m_acc[k] + f;
                        m_acc[k] = s % (1 << DW);
                        d = c + ((s >= (1 << DW)) ? 1 : 0);
                    end else begin
                        if (fb) begin
                            m_ch[k] = c; m_ff[k] = f; idx = 0;
                        end else begin
                            idx = m_bcnt + 1;
                        end
                        d = m_ch[k] + ((m_ff[k] >> idx) & 1);
                    end
                    if (!bus.en[k]) begin
                        m_acc[k] = 0; m_ff[k] = 0; d = 0;
                    end
                    if (d > FULL + 1) d = FULL + 1;
                    e[k] = (VW+1)'(d);
                end
                exp_q.push_back(e);
                m_first = 1'b0;
                m_bcnt  = (m_bcnt == DW - 1) ? 0 : m_bcnt + 1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
    end

    // Monitor: strobes checked every cycle they are expected or seen; high
    // time per channel accumulated over each period and checked against the
    // scoreboard entry when the period's last output cycle has been sampled.
    initial begin
        int    seen_rst = 0;
        bit    in_win = 1'b0;
        int    hc [NCH];
        bit    es, ef;
        dvec_t e;
        forever begin
            @(negedge clk);
            if (m_rst_cnt == 0) continue;
            if (m_rst_cnt != seen_rst) begin
                seen_rst = m_rst_cnt;
                in_win   = 1'b0;
                chk("rst_out", int'({bus.pwm_o, bus.pwm_s, bus.frame_s}), 0);
                continue;
            end
            es = (m_cnt == FULL);
            ef = es && (m_bcnt == DW - 1);
            if (es || bus.pwm_s)   chk("pwm_s",   int'(bus.pwm_s),   int'(es));
            if (ef || bus.frame_s) chk("frame_s", int'(bus.frame_s), int'(ef));
            if (m_cnt == 1) begin
                in_win = 1'b1;
                for (int k = 0; k < NCH; k++) hc[k] = 0;
            end
            if (in_win) begin
                for (int k = 0; k < NCH; k++) hc[k] += int'(bus.pwm_o[k]);
                if (m_cnt == 0) begin
                    if (exp_q.size() == 0) begin
                        chk("queue_empty", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        for (int k = 0; k < NCH; k++)
                            chk($sformatf("high_ch%0d", k), hc[k], int'(e[k]));
                    end
                end
            end
        end
    end

    task automatic set_ch(input int k, input logic [VW-1:0] c, input logic [DW-1:0] f);
        bus.cfg[k*CW +: CW] = {c, f};
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt != v && n < 2000);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rstn     = 1'b0;
        bus.cfg  = '0;
        bus.en   = '0;
        bus.mode = '0;
        set_ch(0, 8'd100, 16'h8000);
        set_ch(1, 8'd50,  16'h0005);
        set_ch(2, 8'd200, 16'h0000);
        set_ch(3, 8'd255, 16'hFFFF);
        bus.en   = 4'b1111;
        bus.mode = 4'b0010;
        run(4);
        rstn = 1'b1;

        // Sigma-delta and legacy dither; legacy cfg changed mid-frame
        run(5000);
        set_ch(1, 8'd80, 16'h00A3);
        run(4000);

        // Enable dropped mid-period, then re-enabled with a nonzero frac
        wait_cnt(120);
        bus.en[2] = 1'b0;
        run(3 * 256);
        set_ch(2, 8'd200, 16'h4000);
        wait_cnt(50);
        bus.en[2] = 1'b1;
        run(6 * 256);

        // Mode toggled mid-frame on channel 3
        wait_cnt(100);
        bus.mode[3] = 1'b1;
        set_ch(3, 8'd30, 16'h8001);
        run(8192);
        wait_cnt(10);
        bus.mode[3] = 1'b0;
        run(4096);

        // Reset pulse at cnt=37 with all channels high
        for (int k = 0; k < NCH; k++) set_ch(k, 8'd255, 16'hFFFF);
        bus.mode = '0;
        run(600);
        wait_cnt(37);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        run(1000);

        // Randomised configurations
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < NCH; k++) begin
                set_ch(k, VW'($urandom_range(0, 255)), DW'($urandom));
                bus.en[k]   = ($urandom_range(0, 7) != 0);
                bus.mode[k] = 1'($urandom_range(0, 1));
            end
            run($urandom_range(500, 3000));
        end

        run(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
